// File: rtl/reg_share_arb.sv
// Round-robin write arbiter owning a shared W-bit register.
// One winner per enabled cycle; the winner's lane is loaded and acknowledged by a registered gnt pulse.
module reg_share_arb #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*W-1:0]         wdata,
  output logic [W-1:0]               q,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       valid
);

  localparam int PW = $clog2(N_REQ);

  logic [W-1:0]     q_q,     q_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic             valid_q, valid_d;
  logic [PW-1:0]    ptr_q,   ptr_d;

  logic [N_REQ-1:0] elig;
  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;

  // Requesters acknowledged this cycle sit out, so a held req cannot win twice in a row.
  always_comb begin
    elig  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      idx = PW'((32'(ptr_q) + j) % N_REQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    q_d     = q_q;
    gnt_d   = '0;
    owner_d = owner_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (en && found) begin
      q_d     = W'(wdata >> (32'(win) * W));
      gnt_d   = N_REQ'(1) << win;
      owner_d = win;
      valid_d = 1'b1;
      ptr_d   = PW'((32'(win) + 1) % N_REQ);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else begin
      q_q     <= q_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign q     = q_q;
  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_reg_share_arb.sv
// Bench for reg_share_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_share_arb;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int PW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [N-1:0]      req;
  logic [N*W-1:0]    wdata;
  logic [W-1:0]      q;
  logic [N-1:0]      gnt;
  logic [PW-1:0]     owner;
  logic              valid;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference state.
  int unsigned m_q, m_gnt, m_owner, m_valid, m_ptr;

  reg_share_arb #(.N_REQ(N), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .wdata(wdata),
    .q(q), .gnt(gnt), .owner(owner), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_gnt = 0; m_owner = 0; m_valid = 0; m_ptr = 0;
  endtask

  // One write per edge: scan outward from the priority pointer, skipping the just-granted requester.
  task automatic model_edge();
    int unsigned elig, k;
    if (rst) begin
      model_reset();
      return;
    end
    if (!en) begin
      m_gnt = 0;
      return;
    end
    elig = int'(req) & ~m_gnt & ((1 << N) - 1);
    if (elig == 0) begin
      m_gnt = 0;
      return;
    end
    k = m_ptr;
    while (((elig >> k) & 1) == 0) k = (k + 1) % N;
    m_q     = (int'(wdata) >> (k * W)) & ((1 << W) - 1);
    m_gnt   = 1 << k;
    m_owner = k;
    m_valid = 1;
    m_ptr   = (k + 1) % N;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".q"},     q,     m_q);
    check_val({tag, ".gnt"},   gnt,   m_gnt);
    check_val({tag, ".owner"}, owner, m_owner);
    check_val({tag, ".valid"}, valid, m_valid);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Assert rst between edges and check the asynchronous clear, then release after one held edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_val({tag, ".q0"},     q,     0);
    check_val({tag, ".gnt0"},   gnt,   0);
    check_val({tag, ".owner0"}, owner, 0);
    check_val({tag, ".valid0"}, valid, 0);
    tick({tag, ".held"});
    rst = 1'b0;
  endtask

  function automatic logic [N*W-1:0] lanes(input int unsigned l0, l1, l2, l3);
    return {W'(l3), W'(l2), W'(l1), W'(l0)};
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; req = '1; wdata = lanes(5, 6, 7, 8);
    model_reset();
    #1;
    check_all("por");
    tick("por_hold");
    tick("por_hold");
    rst = 1'b0;
    tick("warm");
    tick("warm");

    // Reset asserted between edges with all requests present.
    req = 4'b1111;
    async_reset("reset");

    // Single requester.
    req = 4'b0100; wdata = lanes(0, 0, 4'hA, 0);
    tick("single");
    check_val("single.q_abs", q, 4'hA);
    check_val("single.gnt_abs", gnt, 4'b0100);
    check_val("single.owner_abs", owner, 2);
    req = 4'b0000;
    tick("single_after");
    check_val("single_after.gnt_abs", gnt, 0);
    check_val("single_after.q_abs", q, 4'hA);

    // Full contention from a fresh pointer.
    async_reset("rst_fc");
    req = 4'b1111; wdata = lanes(1, 2, 3, 4);
    for (int i = 0; i < 8; i++) begin
      tick("contend");
      check_val("contend.gnt_abs", gnt, 1 << (i % 4));
      check_val("contend.q_abs", q, (i % 4) + 1);
    end

    // Masking and wrap: last grant to 2 leaves the pointer at 3.
    async_reset("rst_wrap");
    req = 4'b0100; wdata = lanes(9, 0, 4'hC, 4'hD);
    tick("wrap_pre");
    req = 4'b1001;
    tick("wrap1");
    check_val("wrap1.gnt_abs", gnt, 4'b1000);
    tick("wrap2");
    check_val("wrap2.gnt_abs", gnt, 4'b0001);
    check_val("wrap2.q_abs", q, 9);

    // Enable hold.
    req = 4'b0010; wdata = lanes(0, 4'h7, 0, 0); en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("hold");
      check_val("hold.gnt_abs", gnt, 0);
      check_val("hold.q_abs", q, 9);
    end
    en = 1'b1;
    tick("hold_release");
    check_val("hold_release.gnt_abs", gnt, 4'b0010);
    req = 4'b0000;
    tick("idle");

    // Reset mid-stream under full contention.
    async_reset("rst_ms0");
    req = 4'b1111; wdata = lanes(1, 2, 3, 4);
    tick("ms");
    tick("ms");
    async_reset("rst_ms");
    tick("ms_after");
    check_val("ms_after.gnt_abs", gnt, 4'b0001);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req   = N'($urandom);
      wdata = (N*W)'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin write arbiter and owner of a shared W-bit register with asynchronous reset. N_REQ requesters compete for the register's write port. The block picks at most one winner per cycle, loads that requester's data into the register and returns a registered one-cycle grant pulse as write acknowledgement. The stored value is visible to all requesters and to downstream logic.

## Interface
- N_REQ, 4: number of requesters; legal range 2..8.
- W, 4: width of the shared register and of each write-data lane.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state immediately.
- en  in  1  global enable; when low, no arbitration takes place and all state is held.
- req  in  N_REQ  per-requester write request; bit i belongs to requester i.
- wdata  in  N_REQ*W  flattened write data; requester i owns bits [i*W +: W].
- q  out  W  shared register contents.
- gnt  out  N_REQ  registered one-hot write acknowledge; a one-cycle pulse.
- owner  out  clog2(N_REQ)  index of the requester that performed the last write.
- valid  out  1  high once any write has completed since reset.

## Operation
- Internal state:
  - ptr[clog2(N_REQ)-1:0] is the highest-priority index.
  - q, gnt, owner and valid are all registered.
- Eligibility mask: elig[i] = req[i] & ~gnt[i].
  - A requester acknowledged in the current cycle cannot win again in the same cycle.
- Winner: the first i with elig[i]=1, searching ptr, ptr+1, … modulo N_REQ.
- On a rising edge with en=1 and any elig bit set, for winner k:
  - q <= wdata[k*W +: W].
  - gnt <= one-hot(k).
  - owner <= k.
  - valid <= 1.
  - ptr <= (k+1) mod N_REQ; wraps from N_REQ-1 to 0.
- On a rising edge with en=1 and no elig bit set: gnt <= 0; q, owner, valid and ptr are held.
- On a rising edge with en=0: gnt <= 0; q, owner, valid and ptr are held. Pending requests are neither lost nor reordered.
- Requester protocol:
  - Assert req[i] with stable wdata and hold both until gnt[i]=1 is sampled.
  - Deassert req[i] in the gnt cycle, or keep it asserted to request another write.
  - Dropping req before gnt withdraws the request; nothing is written.
- Data width: W bits are stored unchanged, with no extension or truncation.
- Reset values, applied asynchronously and held while rst=1:
  - q=0, gnt=0, owner=0, valid=0, ptr=0.
- Reset mid-operation: any in-flight grant is lost. The requester never sees gnt and must re-request after rst falls.
- Simultaneous events: rst dominates en and req. Only one write occurs per cycle, regardless of how many requests are present.

## Timing
- Latency: with req[i] sampled high at edge n and requester i winning at n, q and gnt[i] show the new values immediately after edge n. gnt is registered with no combinational path from req.
- gnt[i] is high for exactly one cycle per write.
- Throughput: one write per cycle aggregate; at most one write per two cycles per requester.
- Fairness: under continuous requests from all N_REQ requesters, each requester is granted exactly once in every N_REQ consecutive grants.
- Worst-case wait from req assertion to gnt is N_REQ cycles with en held high.
- All outputs change only on a clk rising edge or on rst assertion.

## Test plan
- Reset:
  - Stimulus: assert rst asynchronously between clock edges with req=4'b1111.
  - Required response: q=0, gnt=0, owner=0 and valid=0 immediately, and no change on edges while rst=1.
- Single requester:
  - Stimulus: after reset, req=4'b0100 with lane 2 = 4'hA.
  - Required response: after the next edge, q=4'hA, gnt=4'b0100, owner=2, valid=1. One cycle later gnt=0 and q remains 4'hA.
- Full contention:
  - Stimulus: req=4'b1111 held for 8 edges with lanes 0..3 = 4'h1, 4'h2, 4'h3, 4'h4.
  - Required response: gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; q follows 1, 2, 3, 4, 1, 2, 3, 4.
- Masking and wrap:
  - Stimulus: ptr=3 (last grant was to requester 2); req=4'b1001.
  - Required response: grant to 3, then grant to 0. Requester 3 is not re-granted in the cycle its gnt is high.
- Enable hold:
  - Stimulus: req=4'b0010, en=0 for 3 edges, then en=1.
  - Required response: gnt=0 and q unchanged for 3 edges, then gnt=4'b0010 one edge after en rises.
- Reset mid-stream:
  - Stimulus: full contention, assert rst after the second grant, release it, and keep req=4'b1111.
  - Required response: all outputs clear at once; the first grant after release goes to requester 0.
